// File: rtl/jk_bank_if.sv
// jk_bank_if: request handshake plus J/K drive and Q feedback between the
// jk_bank_driver (master) and its environment (slave: controller and bank).
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both high; target is sampled only on that edge. req_ready is
// high only while the driver is idle, and there is no backpressure on the
// completion side: done is a single-cycle pulse with err and retries valid
// in the same cycle.
interface jk_bank_if #(
    parameter int WIDTH = 4
) ();
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             busy;
    logic             done;
    logic             err;
    logic [2:0]       retries;

    // Driver side.
    modport master (
        input  req_valid, target, q_fb,
        output req_ready, j, k, busy, done, err, retries
    );

    // Controller/bank side.
    modport slave (
        output req_valid, target, q_fb,
        input  req_ready, j, k, busy, done, err, retries
    );
endinterface

// File: rtl/jk_bank_driver.sv
// jk_bank_driver: drives the J/K inputs of an external bank of WIDTH JK
// flip-flops so the bank reaches a requested target pattern. Excitation is
// derived from a Q snapshot taken when DRIVE is entered; the result is checked
// after a settle window and failed attempts are retried up to MAX_RETRY times.
//
// Optional feature macro: JK_TOGGLE_DRIVE_EN. When defined, changing bits are
// driven with the toggle code J=K=1 instead of separate set/reset codes.
//
// Latency for a first-attempt success is 1 + HOLD_CYCLES + SETTLE_CYCLES + 1
// clock edges from the accept edge to done: the first DRIVE cycle registers
// the excitation computed from the snapshot, the code is then held for
// HOLD_CYCLES, the hold code for SETTLE_CYCLES, and CHECK takes one cycle.
module jk_bank_driver #(
    parameter int WIDTH         = 4,
    parameter int HOLD_CYCLES   = 1,
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_RETRY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    jk_bank_if.master   bus,
    output logic [2:0]  state_dbg
);

    // Parameters clamped to their legal ranges so counters cannot overrun.
    localparam int HOLD_C   = (HOLD_CYCLES   < 1) ? 1 : (HOLD_CYCLES   > 15) ? 15 : HOLD_CYCLES;
    localparam int SETTLE_C = (SETTLE_CYCLES < 1) ? 1 : (SETTLE_CYCLES > 15) ? 15 : SETTLE_CYCLES;
    localparam int RETRY_C  = (MAX_RETRY     < 0) ? 0 : (MAX_RETRY     > 7)  ? 7  : MAX_RETRY;

    localparam logic [3:0] HOLD_LAST   = 4'(HOLD_C - 1);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_C - 1);
    localparam logic [2:0] RETRY_LIMIT = 3'(RETRY_C);

    // FSM encoding.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DRIVE  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [3:0]       phase_cnt;     // cycles spent in the current DRIVE/SETTLE phase
    logic             drive_loaded;  // excitation has been registered onto j/k
    logic [WIDTH-1:0] tgt_q;         // captured target
    logic [WIDTH-1:0] q_snap;        // q_fb sampled on DRIVE entry
    logic [WIDTH-1:0] j_q;
    logic [WIDTH-1:0] k_q;
    logic [WIDTH-1:0] exc_j;
    logic [WIDTH-1:0] exc_k;
    logic [2:0]       retry_cnt;
    logic             err_q;

    logic accept;
    logic hold_done;
    logic settle_done;
    logic match;
    logic can_retry;

    assign accept      = (state == S_IDLE) && bus.req_valid;
    assign hold_done   = drive_loaded && (phase_cnt == HOLD_LAST);
    assign settle_done = (phase_cnt == SETTLE_LAST);
    assign match       = (bus.q_fb == tgt_q);
    assign can_retry   = (retry_cnt < RETRY_LIMIT);

    // Per-bit excitation from the DRIVE-entry snapshot and the captured target.
    always_comb begin
        exc_j = '0;
        exc_k = '0;
`ifdef JK_TOGGLE_DRIVE_EN
        exc_j = q_snap ^ tgt_q;
        exc_k = q_snap ^ tgt_q;
`else
        exc_j = ~q_snap & tgt_q;
        exc_k = q_snap & ~tgt_q;
`endif
    end

    // Next-state decode for the request sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (hold_done) begin
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_done) begin
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!match && can_retry) begin
                    state_nxt = S_DRIVE;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Phase counter: restarts on every DRIVE/SETTLE entry, counts up to the limit only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            phase_cnt <= '0;
        end else if (state != state_nxt) begin
            phase_cnt <= '0;
        end else if (state == S_DRIVE && drive_loaded && phase_cnt != HOLD_LAST) begin
            phase_cnt <= phase_cnt + 4'd1;
        end else if (state == S_SETTLE && phase_cnt != SETTLE_LAST) begin
            phase_cnt <= phase_cnt + 4'd1;
        end
    end

    // Target capture on accept and Q snapshot on every DRIVE entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tgt_q  <= '0;
            q_snap <= '0;
        end else begin
            if (accept) begin
                tgt_q <= bus.target;
            end
            if (state_nxt == S_DRIVE && state != S_DRIVE) begin
                q_snap <= bus.q_fb;
            end
        end
    end

    // J/K drive: excitation on the first DRIVE cycle, hold code everywhere else.
    always_ff @(posedge clk) begin
        if (!reset) begin
            j_q          <= '0;
            k_q          <= '0;
            drive_loaded <= 1'b0;
        end else if (state == S_DRIVE && !drive_loaded) begin
            j_q          <= exc_j;
            k_q          <= exc_k;
            drive_loaded <= 1'b1;
        end else if (state == S_DRIVE && !hold_done) begin
            j_q          <= j_q;
            k_q          <= k_q;
            drive_loaded <= 1'b1;
        end else begin
            j_q          <= '0;
            k_q          <= '0;
            drive_loaded <= 1'b0;
        end
    end

    // Retry counter and error flag: cleared on accept, held after DONE until the next accept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            retry_cnt <= '0;
            err_q     <= 1'b0;
        end else if (accept) begin
            retry_cnt <= '0;
            err_q     <= 1'b0;
        end else if (state == S_CHECK) begin
            if (match) begin
                err_q <= 1'b0;
            end else if (can_retry) begin
                retry_cnt <= retry_cnt + 3'd1;
            end else begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.j         = j_q;
    assign bus.k         = k_q;
    assign bus.req_ready = (state == S_IDLE);
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.err       = err_q;
    assign bus.retries   = retry_cnt;
    assign state_dbg     = state;

endmodule

// File: tb/tb_jk_bank_driver.sv
// tb_jk_bank_driver: directed bench for jk_bank_driver with a behavioural JK
// bank model (with stuck-at-0 and drop-first-update fault injection) and a
// completion scoreboard keyed on the done pulse.
module tb_jk_bank_driver;
    localparam int W = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    jk_bank_if #(.WIDTH(W)) bus ();
    logic [2:0] state_dbg;

    jk_bank_driver #(
        .WIDTH(W), .HOLD_CYCLES(1), .SETTLE_CYCLES(2), .MAX_RETRY(2)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .state_dbg(state_dbg)
    );

    // Bank model
    logic [W-1:0] bank_q;
    logic [W-1:0] bank_load_val;
    logic         bank_load = 1'b0;
    logic [W-1:0] stuck_mask = '0;
    logic [W-1:0] drop_mask  = '0;
    logic [W-1:0] drop_pend;

    assign bus.q_fb = bank_q;

    always @(posedge clk) begin
        logic nxt;
        if (bank_load) begin
            bank_q    <= bank_load_val;
            drop_pend <= drop_mask;
        end else begin
            for (int i = 0; i < W; i++) begin
                case ({bus.j[i], bus.k[i]})
                    2'b00:   nxt = bank_q[i];
                    2'b01:   nxt = 1'b0;
                    2'b10:   nxt = 1'b1;
                    default: nxt = ~bank_q[i];
                endcase
                if (stuck_mask[i]) begin
                    nxt = 1'b0;
                end else if (drop_pend[i] && nxt != bank_q[i]) begin
                    nxt = bank_q[i];
                    drop_pend[i] <= 1'b0;
                end
                bank_q[i] <= nxt;
            end
        end
    end

    // Scoreboard
    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] exp_q[$];   // {err, retries} per expected completion

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && bus.done) begin
            if (exp_q.size() == 0) begin
                check("done_without_request", 32'(bus.done), 32'd0);
            end else begin
                check("done_err_retries", 32'({bus.err, bus.retries}), 32'(exp_q.pop_front()));
            end
        end
    end

    // Reference excitation table
    function automatic logic [2*W-1:0] exp_jk(input logic [W-1:0] q, input logic [W-1:0] t);
`ifdef JK_TOGGLE_DRIVE_EN
        return {q ^ t, q ^ t};
`else
        return {~q & t, q & ~t};
`endif
    endfunction

    // Driver tasks
    task automatic load_bank(input logic [W-1:0] v, input logic [W-1:0] stuck, input logic [W-1:0] drop);
        @(negedge clk);
        stuck_mask    = stuck;
        drop_mask     = drop;
        bank_load_val = v;
        bank_load     = 1'b1;
        @(posedge clk);
        #1 bank_load = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic run_req(input string tag, input logic [W-1:0] start, input logic [W-1:0] tgt,
                           input logic exp_err, input logic [2:0] exp_ret, input int exp_attempts,
                           input int exp_lat, input bit intrude);
        logic [2*W-1:0] ejk;
        logic [W-1:0]   j1, k1;
        logic           drv, prev_drv;
        int             lat, attempts;
        ejk = exp_jk(start, tgt);
        exp_q.push_back({exp_err, exp_ret});
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.target    = tgt;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.target    = 4'($urandom_range(0, 15));
        lat = 0; attempts = 0; prev_drv = 1'b0; j1 = '0; k1 = '0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c == 1) begin
                j1 = bus.j;
                k1 = bus.k;
            end
            drv = (bus.j | bus.k) != '0;
            if (drv && !prev_drv) attempts++;
            prev_drv = drv;
            if (intrude && c == 2) begin
                check({tag, "_ready_busy"}, 32'(bus.req_ready), 32'd0);
                bus.req_valid = 1'b1;
                bus.target    = '1;
            end
            if (intrude && c == 3) bus.req_valid = 1'b0;
            if (bus.done) begin
                lat = c;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(lat != 0), 32'd1);
        check({tag, "_j_first"}, 32'(j1), 32'(ejk[2*W-1:W]));
        check({tag, "_k_first"}, 32'(k1), 32'(ejk[W-1:0]));
        check({tag, "_attempts"}, 32'(attempts), 32'(exp_attempts));
        if (exp_lat != 0) check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        if (!exp_err) check({tag, "_bank"}, 32'(bank_q), 32'(tgt));
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_pulse_len"}, 32'(bus.done), 32'd0);
        check({tag, "_ready_after"}, 32'(bus.req_ready), 32'd1);
    endtask

    // Directed sequence
    initial begin
        bus.req_valid = 1'b1;
        bus.target    = '1;
        reset         = 1'b0;

        // Reset held low with req_valid high
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("reset_j", 32'(bus.j), 32'd0);
            check("reset_k", 32'(bus.k), 32'd0);
            check("reset_busy", 32'(bus.busy), 32'd0);
            check("reset_ready", 32'(bus.req_ready), 32'd1);
            check("reset_done", 32'(bus.done), 32'd0);
            check("reset_retries", 32'({bus.err, bus.retries}), 32'd0);
        end
        bus.req_valid = 1'b0;
        reset = 1'b1;

        load_bank(4'b0000, 4'b0000, 4'b0000);
        run_req("set_1010", 4'b0000, 4'b1010, 1'b0, 3'd0, 1, 5, 1'b0);

        load_bank(4'b1111, 4'b0000, 4'b0000);
        run_req("clr_0101", 4'b1111, 4'b0101, 1'b0, 3'd0, 1, 5, 1'b0);

        load_bank(4'b0110, 4'b0000, 4'b0000);
        run_req("equal", 4'b0110, 4'b0110, 1'b0, 3'd0, 0, 5, 1'b0);

        load_bank(4'b0000, 4'b0001, 4'b0000);
        run_req("stuck", 4'b0000, 4'b0001, 1'b1, 3'd2, 3, 0, 1'b0);
        idle_cycles(3);
        check("stuck_held_status", 32'({bus.err, bus.retries}), 32'({1'b1, 3'd2}));

        load_bank(4'b0000, 4'b0000, 4'b0100);
        run_req("drop_once", 4'b0000, 4'b0100, 1'b0, 3'd1, 2, 0, 1'b0);

        load_bank(4'b0000, 4'b0000, 4'b0000);
        run_req("intrude", 4'b0000, 4'b0011, 1'b0, 3'd0, 1, 5, 1'b1);
        idle_cycles(10);
        check("intrude_bank_kept", 32'(bank_q), 32'(4'b0011));

        // Reset asserted in DRIVE aborts with no done pulse
        load_bank(4'b0000, 4'b0000, 4'b0000);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.target    = 4'b1100;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_j", 32'(bus.j), 32'd0);
        check("abort_k", 32'(bus.k), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_ready", 32'(bus.req_ready), 32'd1);
        check("abort_done", 32'(bus.done), 32'd0);
        reset = 1'b1;
        idle_cycles(10);
        check("abort_bank_untouched", 32'(bank_q), 32'd0);
        check("abort_status", 32'({bus.err, bus.retries}), 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time bound reached");
        $fatal(1, "time bound reached");
    end
endmodule
